// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the LC-3b MEM-stage port; byte-masked word array.
// Optional DMEM_PERF_EN adds saturating request/busy-cycle counters.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [1:0]  d_mem_byte_enable,
  input  logic [15:0] d_mem_address,
  input  logic [15:0] d_mem_wdata,
  output logic        d_mem_resp,
  output logic [15:0] d_mem_rdata
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_req_count,
  output logic [31:0] perf_busy_cycles
`endif
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "dmem_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [15:0]       r_wdata;
  logic [1:0]        r_be;
  logic              r_wr, w_is_wr;
  logic              w_req, w_accept;
  logic              r_resp;
  logic [15:0]       r_rdata;
  logic [15:0]       r_mem [0:(1 << ADDR_W) - 1];
  logic [15:0]       w_addr_unused;

  // Byte bit 0 and bits above the word index are intentionally dropped.
  assign w_addr_unused = d_mem_address;
  assign w_req         = d_mem_read | d_mem_write;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = LAT_M1;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY==1 the read is launched on the accepting edge, before capture lands.
  assign w_addr  = w_accept ? d_mem_address[ADDR_W:1] : r_addr;
  assign w_is_wr = w_accept ? d_mem_write : r_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_wr    <= 1'b0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= d_mem_address[ADDR_W:1];
        r_wdata <= d_mem_wdata;
        r_be    <= d_mem_byte_enable;
        r_wr    <= d_mem_write;
      end
      r_resp  <= (w_next == RESP);
      r_rdata <= (w_next == RESP && !w_is_wr) ? r_mem[w_addr] : '0;
    end
  end

  // Commit happens only on the edge that ends RESP, so a reset before it drops the write.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_wr) begin
      if (r_be[0]) r_mem[r_addr][7:0]  <= r_wdata[7:0];
      if (r_be[1]) r_mem[r_addr][15:8] <= r_wdata[15:8];
    end
  end

  assign d_mem_resp  = r_resp;
  assign d_mem_rdata = r_rdata;

`ifdef DMEM_PERF_EN
  logic [31:0] r_perf_req, r_perf_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_req  <= '0;
      r_perf_busy <= '0;
    end else begin
      if (w_accept && r_perf_req != '1) r_perf_req <= r_perf_req + 32'd1;
      if ((r_state == WAIT || r_state == RESP) && r_perf_busy != '1)
        r_perf_busy <= r_perf_busy + 32'd1;
    end
  end

  assign perf_req_count   = r_perf_req;
  assign perf_busy_cycles = r_perf_busy;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus held-request, reset and perf sequences.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;
  logic        d_mem_read, d_mem_write;
  logic [1:0]  d_mem_byte_enable;
  logic [15:0] d_mem_address, d_mem_wdata;
  logic        d_mem_resp;
  logic [15:0] d_mem_rdata;

  logic        l1_read, l1_write;
  logic [1:0]  l1_be;
  logic [15:0] l1_addr, l1_wdata;
  logic        l1_resp;
  logic [15:0] l1_rdata;

`ifdef DMEM_PERF_EN
  logic [31:0] p_req, p_busy, p1_req, p1_busy;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  dmem_responder #(.ADDR_W(10), .LATENCY(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .d_mem_read       (d_mem_read),
    .d_mem_write      (d_mem_write),
    .d_mem_byte_enable(d_mem_byte_enable),
    .d_mem_address    (d_mem_address),
    .d_mem_wdata      (d_mem_wdata),
    .d_mem_resp       (d_mem_resp),
    .d_mem_rdata      (d_mem_rdata)
`ifdef DMEM_PERF_EN
    ,
    .perf_req_count   (p_req),
    .perf_busy_cycles (p_busy)
`endif
  );

  dmem_responder #(.ADDR_W(4), .LATENCY(1)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .d_mem_read       (l1_read),
    .d_mem_write      (l1_write),
    .d_mem_byte_enable(l1_be),
    .d_mem_address    (l1_addr),
    .d_mem_wdata      (l1_wdata),
    .d_mem_resp       (l1_resp),
    .d_mem_rdata      (l1_rdata)
`ifdef DMEM_PERF_EN
    ,
    .perf_req_count   (p1_req),
    .perf_busy_cycles (p1_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] addr, input logic [15:0] wd);
    if (sel) begin
      l1_read = rd; l1_write = wr; l1_be = be; l1_addr = addr; l1_wdata = wd;
    end else begin
      d_mem_read = rd; d_mem_write = wr; d_mem_byte_enable = be;
      d_mem_address = addr; d_mem_wdata = wd;
    end
  endtask

  function automatic logic resp_of(input bit sel);
    return sel ? l1_resp : d_mem_resp;
  endfunction

  function automatic logic [15:0] rdata_of(input bit sel);
    return sel ? l1_rdata : d_mem_rdata;
  endfunction

  // Starts and ends on a falling edge; request held until the resp cycle ends.
  task automatic txn(input vec_t v, input string nm);
    int          lat;
    logic        seen;
    logic [15:0] got;
    drive(v.sel, v.rd, v.wr, v.be, v.addr, v.wdata);
    lat = 0; seen = 1'b0; got = '0;
    for (int c = 1; c <= 32 && !seen; c++) begin
      @(posedge clk); @(negedge clk);
      if (resp_of(v.sel)) begin
        seen = 1'b1; lat = c; got = rdata_of(v.sel);
      end
    end
    check({nm, " latency"}, lat, v.lat);
    check({nm, " rdata"}, got, v.exp);
    @(posedge clk); @(negedge clk);
    drive(v.sel, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check({nm, " resp one-cycle"}, resp_of(v.sel), 1'b0);
    check({nm, " rdata idle"}, rdata_of(v.sel), 16'h0000);
  endtask

  initial begin
    int   pulses, first, second, cnt;
    logic seen;
    vec_t v;

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);

    //        sel  rd    wr    be     addr      wdata     exp       lat
    vecs[0]  = '{0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF, 16'h0000, 3};
    vecs[1]  = '{0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 3};
    vecs[2]  = '{0, 1'b0, 1'b1, 2'b11, 16'h0020, 16'h1234, 16'h0000, 3};
    vecs[3]  = '{0, 1'b0, 1'b1, 2'b10, 16'h0020, 16'hAB00, 16'h0000, 3};
    vecs[4]  = '{0, 1'b1, 1'b0, 2'b01, 16'h0021, 16'h0000, 16'hAB34, 3};
    vecs[5]  = '{0, 1'b0, 1'b1, 2'b11, 16'h0800, 16'h5555, 16'h0000, 3};
    vecs[6]  = '{0, 1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h5555, 3};
    vecs[7]  = '{0, 1'b0, 1'b1, 2'b11, 16'h0030, 16'h1111, 16'h0000, 3};
    vecs[8]  = '{0, 1'b0, 1'b1, 2'b01, 16'h0030, 16'h99CD, 16'h0000, 3};
    vecs[9]  = '{0, 1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h11CD, 3};
    vecs[10] = '{0, 1'b0, 1'b1, 2'b00, 16'h0030, 16'hFFFF, 16'h0000, 3};
    vecs[11] = '{0, 1'b1, 1'b0, 2'b00, 16'h0031, 16'h0000, 16'h11CD, 3};
    vecs[12] = '{0, 1'b1, 1'b1, 2'b11, 16'h0030, 16'h2222, 16'h0000, 3};
    vecs[13] = '{0, 1'b1, 1'b0, 2'b00, 16'h0030, 16'h0000, 16'h2222, 3};
    vecs[14] = '{0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'h0001, 16'h0000, 3};
    vecs[15] = '{0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0001, 3};
    vecs[16] = '{1, 1'b0, 1'b1, 2'b11, 16'h0002, 16'h00A5, 16'h0000, 1};
    vecs[17] = '{1, 1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h00A5, 1};
    vecs[18] = '{1, 1'b0, 1'b1, 2'b11, 16'h0022, 16'h7777, 16'h0000, 1};
    vecs[19] = '{1, 1'b1, 1'b0, 2'b00, 16'h0003, 16'h0000, 16'h7777, 1};

    repeat (2) @(negedge clk);
    check("reset resp", d_mem_resp, 1'b0);
    check("reset rdata", d_mem_rdata, 16'h0000);
    check("reset resp L1", l1_resp, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) txn(vecs[i], $sformatf("vec%0d", i));

    // Held read: re-accepted only after the idle gap, so pulses land at cycles 3 and 7.
    drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    pulses = 0; first = 0; second = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); @(negedge clk);
      if (d_mem_resp) begin
        pulses++;
        if (pulses == 1) first = c;
        else if (pulses == 2) second = c;
        check($sformatf("held rdata c%0d", c), d_mem_rdata, 16'hBEEF);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    check("held pulse count", pulses, 2);
    check("held first pulse", first, 3);
    check("held second pulse", second, 7);
    repeat (5) @(negedge clk);

    // Reset during WAIT of a write: no response and no commit.
    drive(1'b0, 1'b0, 1'b1, 2'b11, 16'h0040, 16'hFFFF);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (d_mem_resp) seen = 1'b1;
    end
    check("rst-wait no resp", seen, 1'b0);
    v = '{0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0001, 3};
    txn(v, "rst-wait readback");

    // Reset during RESP: resp drops asynchronously.
    drive(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("pre-rst resp", d_mem_resp, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst-resp drop", d_mem_resp, 1'b0);
    check("rst-resp rdata", d_mem_rdata, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    #1 rst_n = 1'b1;
    @(negedge clk);

`ifdef DMEM_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("perf req reset", p_req, 32'd0);
    check("perf busy reset", p_busy, 32'd0);
    v = '{0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 3};
    cnt = 4;
    for (int i = 0; i < cnt; i++) txn(v, $sformatf("perf rd%0d", i));
    check("perf req count", p_req, 32'd4);
    check("perf busy cycles", p_busy, 32'd12);
`else
    cnt = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
